ncpu32k_ie_lu_wb: RTL and testbench
===================================

NCPU32K_IE_LU_WB -- requirements
Module: ncpu32k_ie_lu_wb

Interface
REQ-001 Parameter DW, default 32, data width of logic-unit results.
REQ-002 Parameter AW, default 5, destination register address width.
REQ-003 Parameter OPW, default `NCPU_LU_IOPW, width of the one-hot LU opcode bus.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  synchronous pipeline flush from the IEU.
REQ-007 lu_valid_in  input  1  issue side presents a completed LU operation.
REQ-008 lu_ready_in  output  1  block can accept the operation this cycle.
REQ-009 lu_opc_bus  input  OPW  one-hot opcode (bits `NCPU_LU_AND, _OR, _XOR, _LSL, _LSR, _ASR).
REQ-010 lu_and, lu_or, lu_xor, lu_shift  input  DW each  candidate results from the logic unit.
REQ-011 lu_rd_addr  input  AW  destination register.
REQ-012 wb_valid  output  1  writeback entry available.
REQ-013 wb_ready  input  1  register file accepts the entry.
REQ-014 wb_dat  output  DW  selected result.
REQ-015 wb_addr  output  AW  destination register of wb_dat.
REQ-016 wb_err  output  1  entry's opcode was zero or not one-hot.

Function
REQ-017 Select: AND->lu_and; OR->lu_or; XOR->lu_xor; LSL/LSR/ASR->lu_shift; zero or multi-hot opcode->data 0 with err=1.
REQ-018 Storage is a 2-entry FIFO of {dat, addr, err}: 1-bit read pointer, 1-bit write pointer, 2-bit count 0..2.
REQ-019 lu_ready_in SHALL equal (count != 2) and SHALL NOT depend combinationally on wb_ready.
REQ-020 Push when lu_valid_in & lu_ready_in; pop when wb_valid & wb_ready; simultaneous push and pop leaves count unchanged and advances both pointers.
REQ-021 wb_valid = (count != 0); wb_dat/wb_addr/wb_err come from the head entry, in order of acceptance.
REQ-022 Pointers wrap 1->0; count SHALL never exceed 2 or underflow below 0.
REQ-023 While wb_valid & ~wb_ready, wb_dat, wb_addr and wb_err SHALL hold stable.
REQ-024 flush SHALL set count and both pointers to 0 next cycle and discard any push in the same cycle; it dominates push and pop.
REQ-025 Latency without bypass: an operation accepted in cycle N appears on wb_valid in cycle N+1.

Reset
REQ-026 rst SHALL clear count, read pointer and write pointer; wb_valid=0 and lu_ready_in=1 from the cycle after rst is sampled high.
REQ-027 FIFO data storage SHALL NOT be reset; wb_dat/wb_addr/wb_err are don't-care while wb_valid=0.
REQ-028 rst asserted mid-transfer SHALL drop all pending entries with no writeback; rst dominates flush.

Configuration
REQ-029 Macro NCPU_LU_WB_BYPASS_EN enables a zero-latency bypass; the default is undefined (no bypass).
REQ-030 With NCPU_LU_WB_BYPASS_EN undefined, operation is exactly REQ-017..REQ-025.
REQ-031 With it defined and count==0 (no flush), lu_valid_in SHALL assert wb_valid the same cycle, carrying the combinationally selected dat/addr/err.
REQ-032 In the REQ-031 case, wb_ready=1 consumes the operation without a FIFO write; wb_ready=0 writes it into the FIFO, and it appears from the head in the next cycle.
REQ-033 With bypass enabled, lu_ready_in remains (count != 2).

Verification
REQ-034 No bypass: opc=AND, lu_and=0x0000_00F0, rd=3, wb_ready=1 -> cycle N+1 wb_valid=1, wb_dat=0x0000_00F0, wb_addr=3, wb_err=0; one cycle only.
REQ-035 wb_ready=0, push LSL (0x8000_0000, rd=1), push XOR (0x5A5A_5A5A, rd=2) -> lu_ready_in=0; third push ignored; wb_ready=1 then yields the two entries in order.
REQ-036 Full FIFO, push and pop in the same cycle -> lu_ready_in=0, pop only, count goes 2->1.
REQ-037 opc=0 or opc=AND|OR -> wb_dat=0, wb_err=1.
REQ-038 Two entries queued, then flush together with lu_valid_in=1 -> next cycle wb_valid=0, count=0, the pushed operation is discarded.
REQ-039 Bypass build, empty FIFO, wb_ready=1, opc=OR, lu_or=0x1234_5678 -> wb_valid=1 with wb_dat=0x1234_5678 in the same cycle, count stays 0.

Source files
------------

// File: rtl/ncpu32k_ie_lu_wb.sv
// ncpu32k_ie_lu_wb: LU result select + 2-entry writeback FIFO; optional NCPU_LU_WB_BYPASS_EN zero-latency bypass
`ifndef NCPU_LU_AND
`define NCPU_LU_AND 0
`endif
`ifndef NCPU_LU_OR
`define NCPU_LU_OR 1
`endif
`ifndef NCPU_LU_XOR
`define NCPU_LU_XOR 2
`endif
`ifndef NCPU_LU_LSL
`define NCPU_LU_LSL 3
`endif
`ifndef NCPU_LU_LSR
`define NCPU_LU_LSR 4
`endif
`ifndef NCPU_LU_ASR
`define NCPU_LU_ASR 5
`endif
`ifndef NCPU_LU_IOPW
`define NCPU_LU_IOPW 6
`endif

module ncpu32k_ie_lu_wb #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int OPW = `NCPU_LU_IOPW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           lu_valid_in,
  output logic           lu_ready_in,
  input  logic [OPW-1:0] lu_opc_bus,
  input  logic [DW-1:0]  lu_and,
  input  logic [DW-1:0]  lu_or,
  input  logic [DW-1:0]  lu_xor,
  input  logic [DW-1:0]  lu_shift,
  input  logic [AW-1:0]  lu_rd_addr,
  output logic           wb_valid,
  input  logic           wb_ready,
  output logic [DW-1:0]  wb_dat,
  output logic [AW-1:0]  wb_addr,
  output logic           wb_err
);
  logic [1:0][DW-1:0] dat_q, dat_d;
  logic [1:0][AW-1:0] addr_q, addr_d;
  logic [1:0]         err_q, err_d;
  logic               rd_q, rd_d, wr_q, wr_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [DW-1:0]      sel_dat;
  logic               sel_err, byp, push, pop;

`ifdef NCPU_LU_WB_BYPASS_EN
  assign byp = lu_valid_in & (cnt_q == 2'd0) & ~flush;
`else
  assign byp = 1'b0;
`endif

  // result select, queue control and outputs; a bypassed op taken by wb_ready never enters the queue
  always_comb begin
    sel_err = !$onehot(lu_opc_bus);
    sel_dat = sel_err ? '0 :
              lu_opc_bus[`NCPU_LU_AND] ? lu_and :
              lu_opc_bus[`NCPU_LU_OR]  ? lu_or :
              lu_opc_bus[`NCPU_LU_XOR] ? lu_xor : lu_shift;
    lu_ready_in = cnt_q != 2'd2;
    wb_valid = (cnt_q != 2'd0) | byp;
    wb_dat  = byp ? sel_dat : dat_q[rd_q];
    wb_addr = byp ? lu_rd_addr : addr_q[rd_q];
    wb_err  = byp ? sel_err : err_q[rd_q];
    push = lu_valid_in & lu_ready_in & ~flush & ~(byp & wb_ready);
    pop  = (cnt_q != 2'd0) & wb_ready & ~flush;
    rd_d = flush ? 1'b0 : rd_q ^ pop;
    wr_d = flush ? 1'b0 : wr_q ^ push;
    cnt_d = flush ? 2'd0 :
            (push & ~pop) ? cnt_q + 2'd1 :
            (pop & ~push) ? cnt_q - 2'd1 : cnt_q;
    dat_d = dat_q;
    addr_d = addr_q;
    err_d = err_q;
    if (push) begin
      dat_d[wr_q]  = sel_dat;
      addr_d[wr_q] = lu_rd_addr;
      err_d[wr_q]  = sel_err;
    end
  end

  // queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 2'd0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
    end
  end

  // entry storage, never reset: contents are ignored while empty
  always_ff @(posedge clk) begin
    dat_q  <= dat_d;
    addr_q <= addr_d;
    err_q  <= err_d;
  end
endmodule

// File: tb/tb_ncpu32k_ie_lu_wb.sv
// tb_ncpu32k_ie_lu_wb: directed + random scoreboard bench for ncpu32k_ie_lu_wb (default build)
module tb_ncpu32k_ie_lu_wb;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, lu_valid_in = 1'b0, wb_ready = 1'b0;
  logic [5:0]  lu_opc_bus = '0;
  logic [31:0] lu_and = '0, lu_or = '0, lu_xor = '0, lu_shift = '0;
  logic [4:0]  lu_rd_addr = '0;
  logic        lu_ready_in, wb_valid, wb_err;
  logic [31:0] wb_dat;
  logic [4:0]  wb_addr;
  logic [37:0] sb[$];
  int          mcnt = 0, checks = 0, errors = 0;

  ncpu32k_ie_lu_wb dut (
    .clk(clk), .rst(rst), .flush(flush), .lu_valid_in(lu_valid_in), .lu_ready_in(lu_ready_in),
    .lu_opc_bus(lu_opc_bus), .lu_and(lu_and), .lu_or(lu_or), .lu_xor(lu_xor), .lu_shift(lu_shift),
    .lu_rd_addr(lu_rd_addr), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dat(wb_dat),
    .wb_addr(wb_addr), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [37:0] got, input logic [37:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] expect_of(input logic [5:0] o, input logic [31:0] a, input logic [31:0] r,
                                            input logic [31:0] x, input logic [31:0] s, input logic [4:0] rd);
    case (o)
      6'h01: return {a, rd, 1'b0};
      6'h02: return {r, rd, 1'b0};
      6'h04: return {x, rd, 1'b0};
      6'h08, 6'h10, 6'h20: return {s, rd, 1'b0};
      default: return {32'h0, rd, 1'b1};
    endcase
  endfunction

  task automatic step(input logic v, input logic [5:0] o, input logic [31:0] val, input logic [4:0] rd,
                      input logic rdy, input logic fl);
    lu_valid_in = v; lu_opc_bus = o; wb_ready = rdy; flush = fl; lu_rd_addr = rd;
    lu_and = val; lu_or = ~val; lu_xor = val ^ 32'h5A5A_5A5A; lu_shift = {val[15:0], val[31:16]};
    #4;
    chk("ready", {37'h0, lu_ready_in}, {37'h0, mcnt != 2});
    chk("valid", {37'h0, wb_valid}, {37'h0, mcnt != 0});
    if (mcnt != 0) chk("head", {wb_dat, wb_addr, wb_err}, sb[0]);
    if (fl) begin
      sb.delete();
      mcnt = 0;
    end else begin
      if (mcnt != 0 && rdy) begin
        void'(sb.pop_front());
        mcnt--;
      end
      if (v && mcnt + (rdy && sb.size() != mcnt ? 1 : 0) != 2 && lu_ready_in_model(v)) begin
        sb.push_back(expect_of(o, lu_and, lu_or, lu_xor, lu_shift, rd));
        mcnt++;
      end
    end
    @(posedge clk); #1;
  endtask

  int pre_cnt;
  function automatic bit lu_ready_in_model(input logic v);
    return v && pre_cnt != 2;
  endfunction

  task automatic op(input logic v, input logic [5:0] o, input logic [31:0] val, input logic [4:0] rd,
                    input logic rdy, input logic fl = 1'b0);
    pre_cnt = mcnt;
    step(v, o, val, rd, rdy, fl);
  endtask

  task automatic do_reset(input logic v);
    rst = 1'b1; lu_valid_in = v; flush = v; wb_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; lu_valid_in = 1'b0;
    sb.delete();
    mcnt = 0;
  endtask

  logic [5:0] opcs [8] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h00, 6'h03};

  initial begin
    do_reset(1'b0);
    op(0, 6'h00, 32'h0, 5'd0, 1);
    op(1, 6'h01, 32'h0000_00F0, 5'd3, 1);
    op(0, 6'h00, 32'h0, 5'd0, 1);
    op(0, 6'h00, 32'h0, 5'd0, 1);
    op(1, 6'h08, 32'h0000_8000, 5'd1, 0);
    op(1, 6'h04, 32'h0000_0000, 5'd2, 0);
    op(1, 6'h02, 32'hDEAD_BEEF, 5'd7, 0);
    op(0, 6'h00, 32'h0, 5'd0, 0);
    op(0, 6'h00, 32'h0, 5'd0, 1);
    op(0, 6'h00, 32'h0, 5'd0, 1);
    op(1, 6'h10, 32'h1111_2222, 5'd8, 0);
    op(1, 6'h20, 32'h3333_4444, 5'd9, 0);
    op(1, 6'h01, 32'h5555_6666, 5'd10, 1);
    op(0, 6'h00, 32'h0, 5'd0, 0);
    op(0, 6'h00, 32'h0, 5'd0, 1);
    op(1, 6'h00, 32'hFFFF_FFFF, 5'd4, 1);
    op(1, 6'h03, 32'hFFFF_FFFF, 5'd5, 1);
    op(0, 6'h00, 32'h0, 5'd0, 1);
    op(0, 6'h00, 32'h0, 5'd0, 1);
    op(1, 6'h01, 32'hAAAA_0001, 5'd11, 0);
    op(1, 6'h02, 32'hAAAA_0002, 5'd12, 0);
    op(1, 6'h04, 32'hAAAA_0003, 5'd13, 1, 1);
    op(0, 6'h00, 32'h0, 5'd0, 1);
    for (int i = 0; i < 60; i++)
      op(1'($urandom_range(0, 1)), opcs[$urandom_range(0, 7)], $urandom, 5'($urandom),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    op(1, 6'h01, 32'hBBBB_0001, 5'd14, 0);
    op(1, 6'h02, 32'hBBBB_0002, 5'd15, 0);
    do_reset(1'b1);
    op(0, 6'h00, 32'h0, 5'd0, 1);
    for (int i = 0; i < 3; i++) op(0, 6'h00, 32'h0, 5'd0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
